// File: rtl/vic_vect_arbiter_pkg.sv
// Shared sizing defaults and control-field layout for the vectored interrupt arbiter.
// No logic; constants and helpers only.
// No backpressure.
package vic_vect_arbiter_pkg;

    localparam int DEF_NUM_SRC   = 32;
    localparam int DEF_NUM_SLOTS = 16;
    localparam int DEF_SRC_W     = 5;

    // Per-slot control field: enable in the top bit, source number below it.
    localparam int CNTL_SRC_LSB = 0;

    function automatic int cntl_en_bit(input int src_w);
        return src_w;
    endfunction

    // The default channel sits just past the last vectored slot.
    function automatic int def_chan_idx(input int num_slots);
        return num_slots;
    endfunction

endpackage

// File: rtl/vic_prio_enc.sv
// Fixed-priority find-first-set: lowest set bit index wins.
// Latency: combinational.
// No backpressure.
module vic_prio_enc #(
    parameter int W     = 17,
    parameter int IDX_W = $clog2(W)
) (
    input  logic [W-1:0]     i_vec,
    output logic             o_vld,
    output logic [IDX_W-1:0] o_idx
);

    always_comb begin
        o_vld = |i_vec;
        o_idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/vic_vect_arbiter.sv
// Vectored interrupt arbiter: prioritised slots plus a default channel, with nesting.
// Latency: one HCLK from IRQStatus to irqOut/vectAddrOut.
// No backpressure; the CPU acknowledges via vectAddrRead and retires via vectAddrWrite.
module vic_vect_arbiter
    import vic_vect_arbiter_pkg::*;
#(
    parameter int NUM_SRC   = DEF_NUM_SRC,
    parameter int NUM_SLOTS = DEF_NUM_SLOTS,
    parameter int SRC_W     = DEF_SRC_W
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [NUM_SLOTS*(SRC_W+1)-1:0] VICVectCntl,
    input  logic [NUM_SLOTS*32-1:0]      VICVectAddr,
    input  logic [31:0]                  DefVectAddr,
    input  logic [NUM_SRC-1:0]           IRQStatus,
    input  logic                         vectAddrRead,
    input  logic                         vectAddrWrite,
    output logic                         irqOut,
    output logic [31:0]                  vectAddrOut,
    output logic [NUM_SLOTS:0]           inService
);

    localparam int CW    = SRC_W + 1;
    localparam int NCH   = NUM_SLOTS + 1;
    localparam int IDX_W = $clog2(NCH);
    localparam int EN_B  = cntl_en_bit(SRC_W);
    localparam int DEF_I = def_chan_idx(NUM_SLOTS);

    logic [NCH-1:0]     r_in_service;
    logic               r_irq;
    logic [31:0]        r_vect_addr;
    logic [IDX_W-1:0]   r_cur_idx;

    logic [NCH-1:0]     w_hit;
    logic [NUM_SRC-1:0] w_sel_mask;
    logic [NCH-1:0]     w_elig_mask;
    logic [NCH-1:0]     w_elig_hit;
    logic               w_ins_vld;
    logic [IDX_W-1:0]   w_ins_idx;
    logic               w_win_vld;
    logic [IDX_W-1:0]   w_win_idx;
    logic [31:0]        w_win_addr;
    logic [NCH-1:0]     w_ins_nxt;

    // Sources outside NUM_SRC never match, so out-of-range selects never hit.
    always_comb begin
        w_hit      = '0;
        w_sel_mask = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (VICVectCntl[k*CW + EN_B] &&
                    (VICVectCntl[k*CW + CNTL_SRC_LSB +: SRC_W] == SRC_W'(s))) begin
                    w_sel_mask[s] = 1'b1;
                    if (IRQStatus[s]) begin
                        w_hit[k] = 1'b1;
                    end
                end
            end
        end
        w_hit[DEF_I] = |(IRQStatus & ~w_sel_mask);
    end

    vic_prio_enc #(.W(NCH), .IDX_W(IDX_W)) u_ins_enc (
        .i_vec (r_in_service),
        .o_vld (w_ins_vld),
        .o_idx (w_ins_idx)
    );

    always_comb begin
        w_elig_mask = '0;
        for (int i = 0; i < NCH; i++) begin
            w_elig_mask[i] = !w_ins_vld || (IDX_W'(i) < w_ins_idx);
        end
        w_elig_hit = w_hit & w_elig_mask;
    end

    vic_prio_enc #(.W(NCH), .IDX_W(IDX_W)) u_win_enc (
        .i_vec (w_elig_hit),
        .o_vld (w_win_vld),
        .o_idx (w_win_idx)
    );

    always_comb begin
        w_win_addr = DefVectAddr;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (w_win_idx == IDX_W'(k)) begin
                w_win_addr = VICVectAddr[k*32 +: 32];
            end
        end
    end

    // EOI retires the innermost level; an acknowledge in the same cycle then sets its own bit.
    always_comb begin
        w_ins_nxt = r_in_service;
        if (vectAddrWrite && w_ins_vld) begin
            w_ins_nxt[w_ins_idx] = 1'b0;
        end
        if (vectAddrRead && r_irq) begin
            w_ins_nxt[r_cur_idx] = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_irq        <= 1'b0;
            r_vect_addr  <= 32'h0;
            r_cur_idx    <= '0;
            r_in_service <= '0;
        end else begin
            r_irq        <= w_win_vld;
            r_in_service <= w_ins_nxt;
            if (w_win_vld) begin
                r_vect_addr <= w_win_addr;
                r_cur_idx   <= w_win_idx;
            end
        end
    end

    assign irqOut      = r_irq;
    assign vectAddrOut = r_vect_addr;
    assign inService   = r_in_service;

endmodule
